// File: rtl/ifd_fetch_decode_if.sv
// ifd_fetch_decode_if: exec handshake and memory read bus of the PDP-8 fetch/decode unit
interface ifd_fetch_decode_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  stall;
    logic [ADDR_WIDTH-1:0] PC_value;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [5:0]            mem_op;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [21:0]           op7;
    logic                  ifd_rd_req;
    logic [ADDR_WIDTH-1:0] ifd_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  mem_rd_valid;
    logic                  illegal_instr;

    modport master (
        input  stall, PC_value, mem_rd_data, mem_rd_valid,
        output base_addr, mem_op, mem_addr, op7, ifd_rd_req, ifd_rd_addr, illegal_instr
    );
    modport slave (
        output stall, PC_value, mem_rd_data, mem_rd_valid,
        input  base_addr, mem_op, mem_addr, op7, ifd_rd_req, ifd_rd_addr, illegal_instr
    );
endinterface

// File: rtl/ifd_fetch_decode.sv
// ifd_fetch_decode: PDP-8 fetch, one-level indirect resolve and one-hot decode with stall handshake
module ifd_fetch_decode #(
    parameter int                    ADDR_WIDTH    = 12,
    parameter int                    DATA_WIDTH    = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200
) (
    input logic               clk,
    input logic               reset,
    ifd_fetch_decode_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, FETCH_WAIT, IND, IND_WAIT, ISSUE, DRAIN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:7] page;
    logic [5:0]            pend;
    logic [DATA_WIDTH-1:0] ir;
    logic [2:0]            opcode;
    logic [ADDR_WIDTH-1:0] ea;
    logic [4:0]            opr_idx;
    logic                  opr_ok;

    assign bus.base_addr = START_ADDRESS;
    assign ir            = bus.mem_rd_data;
    assign opcode        = ir[11:9];
    assign ea            = ir[7] ? {page, ir[6:0]} : {{(ADDR_WIDTH-7){1'b0}}, ir[6:0]};

    // Only exact microcoded combinations are supported; anything else falls back to NOP
    always_comb begin
        opr_ok = 1'b1;
        case (ir)
            12'o7600: opr_idx = 5'd0;
            12'o7510: opr_idx = 5'd1;
            12'o7500: opr_idx = 5'd2;
            12'o7450: opr_idx = 5'd3;
            12'o7440: opr_idx = 5'd4;
            12'o7430: opr_idx = 5'd5;
            12'o7420: opr_idx = 5'd6;
            12'o7410: opr_idx = 5'd7;
            12'o7404: opr_idx = 5'd8;
            12'o7402: opr_idx = 5'd9;
            12'o7300: opr_idx = 5'd10;
            12'o7200: opr_idx = 5'd11;
            12'o7100: opr_idx = 5'd12;
            12'o7041: opr_idx = 5'd13;
            12'o7040: opr_idx = 5'd14;
            12'o7020: opr_idx = 5'd15;
            12'o7012: opr_idx = 5'd16;
            12'o7010: opr_idx = 5'd17;
            12'o7006: opr_idx = 5'd18;
            12'o7004: opr_idx = 5'd19;
            12'o7001: opr_idx = 5'd20;
            12'o7000: opr_idx = 5'd21;
            default: begin
                opr_idx = 5'd21;
                opr_ok  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            page              <= '0;
            pend              <= '0;
            bus.mem_op        <= '0;
            bus.mem_addr      <= '0;
            bus.op7           <= '0;
            bus.ifd_rd_req    <= 1'b0;
            bus.ifd_rd_addr   <= '0;
            bus.illegal_instr <= 1'b0;
        end else begin
            bus.illegal_instr <= 1'b0;
            case (state)
                IDLE, DRAIN: if (!bus.stall) begin
                    page            <= bus.PC_value[ADDR_WIDTH-1:7];
                    bus.ifd_rd_req  <= 1'b1;
                    bus.ifd_rd_addr <= bus.PC_value;
                    state           <= FETCH;
                end
                FETCH: begin
                    bus.ifd_rd_req <= 1'b0;
                    state          <= FETCH_WAIT;
                end
                FETCH_WAIT: if (bus.mem_rd_valid) begin
                    if (opcode < 3'd6) begin
                        pend <= 6'b100000 >> opcode;
                        if (ir[8]) begin
                            bus.ifd_rd_req  <= 1'b1;
                            bus.ifd_rd_addr <= ea;
                            state           <= IND;
                        end else begin
                            bus.mem_op   <= 6'b100000 >> opcode;
                            bus.mem_addr <= ea;
                            state        <= ISSUE;
                        end
                    end else begin
                        bus.op7           <= 22'(1) << opr_idx;
                        bus.illegal_instr <= opcode == 3'd6 || !opr_ok;
                        state             <= ISSUE;
                    end
                end
                IND: begin
                    bus.ifd_rd_req <= 1'b0;
                    state          <= IND_WAIT;
                end
                IND_WAIT: if (bus.mem_rd_valid) begin
                    bus.mem_op   <= pend;
                    bus.mem_addr <= ir[ADDR_WIDTH-1:0];
                    state        <= ISSUE;
                end
                ISSUE: if (bus.stall) begin
                    bus.mem_op   <= '0;
                    bus.mem_addr <= '0;
                    bus.op7      <= '0;
                    state        <= DRAIN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_mem_op_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.mem_op));
    a_op7_onehot:    assert property (@(posedge clk) disable iff (reset) $onehot0(bus.op7));
    a_exclusive:     assert property (@(posedge clk) disable iff (reset) !(|bus.mem_op && |bus.op7));
    a_one_read:      assert property (@(posedge clk) disable iff (reset)
                                      (state inside {FETCH_WAIT, IND_WAIT}) |-> !bus.ifd_rd_req);
endmodule

// File: tb/tb_ifd_fetch_decode.sv
// tb_ifd_fetch_decode: scoreboard bench with a variable-latency memory and an exec stall model
module tb_ifd_fetch_decode;
    typedef struct packed {
        logic [5:0]  mem_op;
        logic [11:0] mem_addr;
        logic [21:0] op7;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] mem [0:4095];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ws = 0;
    int          cnt = 0;
    logic [11:0] rsp_addr;

    ifd_fetch_decode_if bus();

    ifd_fetch_decode dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Memory answers ws cycles after the request cycle; reset does not cancel a pending answer
    always @(posedge clk) begin
        bus.mem_rd_valid <= 1'b0;
        if (bus.ifd_rd_req) begin
            if (ws == 0) begin
                bus.mem_rd_valid <= 1'b1;
                bus.mem_rd_data  <= mem[bus.ifd_rd_addr];
            end else begin
                cnt      <= ws;
                rsp_addr <= bus.ifd_rd_addr;
            end
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                bus.mem_rd_valid <= 1'b1;
                bus.mem_rd_data  <= mem[rsp_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_op(input logic [11:0] pc, input logic [11:0] word, input logic [5:0] mo,
                             input logic [11:0] addr, input logic [21:0] o7, input logic ill);
        exp_t e;
        mem[pc] = word;
        e.mem_op = mo; e.mem_addr = addr; e.op7 = o7; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [11:0] pc, input int w, input int hold, input bit early, input int busy);
        bit          got;
        exp_t        e;
        logic [39:0] snap;
        ws = w;
        @(negedge clk);
        bus.PC_value = pc;
        bus.stall    = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.ifd_rd_req;
        end
        chk("fetch_req", 64'(got), 64'd1);
        chk("fetch_addr", 64'(bus.ifd_rd_addr), 64'(pc));
        if (early) bus.stall = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = |bus.mem_op || |bus.op7;
        end
        chk("issue_seen", 64'(got), 64'd1);
        if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
        else begin
            e = sb.pop_front();
            chk("mem_op", 64'(bus.mem_op), 64'(e.mem_op));
            chk("mem_addr", 64'(bus.mem_addr), 64'(e.mem_addr));
            chk("op7", 64'(bus.op7), 64'(e.op7));
            chk("illegal", 64'(bus.illegal_instr), 64'(e.ill));
        end
        snap = {bus.mem_op, bus.mem_addr, bus.op7};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold", 64'({bus.mem_op, bus.mem_addr, bus.op7}), 64'(snap));
            if (i == 0) chk("ill_pulse", 64'(bus.illegal_instr), 64'd0);
        end
        bus.stall = 1'b1;
        @(negedge clk);
        chk("drain_clear", 64'({bus.mem_op, bus.mem_addr, bus.op7}), 64'd0);
        if (hold == 0) chk("ill_pulse", 64'(bus.illegal_instr), 64'd0);
        for (int i = 0; i < busy; i++) begin
            @(negedge clk);
            chk("no_fetch", 64'({bus.ifd_rd_req, bus.mem_op, bus.op7}), 64'd0);
        end
    endtask

    logic [11:0] opr_word [8] = '{12'o7300, 12'o7041, 12'o7402, 12'o7600, 12'o7001, 12'o7000, 12'o6001, 12'o7003};
    logic [21:0] opr_hot  [8] = '{22'h400, 22'h2000, 22'h200, 22'h1, 22'h100000, 22'h200000, 22'h200000, 22'h200000};
    logic        opr_ill  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bit got;
        reset        = 1'b1;
        bus.stall    = 1'b1;
        bus.PC_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_op", 64'(bus.mem_op), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_op7", 64'(bus.op7), 64'd0);
        chk("rst_rd_req", 64'(bus.ifd_rd_req), 64'd0);
        chk("rst_rd_addr", 64'(bus.ifd_rd_addr), 64'd0);
        chk("rst_illegal", 64'(bus.illegal_instr), 64'd0);
        chk("base_addr", 64'(bus.base_addr), 64'o0200);
        reset = 1'b0;

        expect_op(12'o0200, 12'o1005, 6'b010000, 12'o0005, '0, 1'b0);
        run_op(12'o0200, 0, 3, 1'b0, 1);
        expect_op(12'o0250, 12'o0377, 6'b100000, 12'o0377, '0, 1'b0);
        run_op(12'o0250, 1, 0, 1'b0, 1);
        mem[12'o0010] = 12'o0123;
        expect_op(12'o0300, 12'o5410, 6'b000001, 12'o0123, '0, 1'b0);
        run_op(12'o0300, 0, 1, 1'b0, 1);
        mem[12'o0577] = 12'o4321;
        expect_op(12'o0400, 12'o2777, 6'b001000, 12'o4321, '0, 1'b0);
        run_op(12'o0400, 2, 1, 1'b0, 0);
        expect_op(12'o1000, 12'o3020, 6'b000100, 12'o0020, '0, 1'b0);
        run_op(12'o1000, 0, 0, 1'b1, 1);
        expect_op(12'o7600, 12'o4200, 6'b000010, 12'o7600, '0, 1'b0);
        run_op(12'o7600, 1, 2, 1'b0, 1);

        for (int i = 0; i < 8; i++) begin
            expect_op(12'o2000 + 12'(i), opr_word[i], '0, '0, opr_hot[i], opr_ill[i]);
            run_op(12'o2000 + 12'(i), i % 3, (i == 2) ? 0 : 1, i == 2, 1);
        end

        expect_op(12'o3000, 12'o0005, 6'b100000, 12'o0005, '0, 1'b0);
        run_op(12'o3000, 3, 2, 1'b0, 10);

        // Reset lands while the fetch is waiting on a 3-wait-state memory
        mem[12'o0500] = 12'o1040;
        ws = 3;
        @(negedge clk);
        bus.PC_value = 12'o0500;
        bus.stall    = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.ifd_rd_req;
        end
        chk("rst_test_req", 64'(got), 64'd1);
        @(negedge clk);
        reset     = 1'b1;
        bus.stall = 1'b1;
        @(negedge clk);
        chk("midrst_outs", 64'({bus.mem_op, bus.mem_addr, bus.op7, bus.ifd_rd_req, bus.illegal_instr}), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("late_valid_ignored", 64'({bus.mem_op, bus.op7, bus.ifd_rd_req, bus.illegal_instr}), 64'd0);
        end
        expect_op(12'o0600, 12'o0205, 6'b100000, 12'o0605, '0, 1'b0);
        run_op(12'o0600, 0, 1, 1'b0, 1);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
